regfile_wb_queue: RTL and testbench
===================================

REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of pending write-back entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-low reset: 0 sampled at a rising clk edge resets the block.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the upstream write-back request is valid.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the queue can accept a request this cycle.
REQ-006 The block SHALL have port in_dr, input, 5, the destination register index.
REQ-007 The block SHALL have port in_data, input, 32, the write data.
REQ-008 The block SHALL have port wb_hold, input, 1, which stalls draining to the register file when 1.
REQ-009 The block SHALL have port dr, output, 5, the register-file write index (registered).
REQ-010 The block SHALL have port wrData, output, 32, the register-file write data (registered).
REQ-011 The block SHALL have port write, output, 1, the register-file write enable (registered).
REQ-012 The block SHALL have port chk_sr, input, 5, the register index for a pending-write lookup.
REQ-013 The block SHALL have port chk_hit, output, 1, meaning a pending write to chk_sr exists.
REQ-014 The block SHALL have port chk_data, output, 32, the youngest pending data for chk_sr.
REQ-015 The block SHALL have port count, output, $clog2(DEPTH)+1, the number of queued entries, excluding the output register.

Function
REQ-016 A push SHALL occur at an edge where in_valid=1 and in_ready=1, appending {in_dr,in_data} at the tail.
REQ-017 in_ready SHALL equal (count < DEPTH), combinational from state only, and independent of any same-cycle pop.
REQ-018 At an edge where wb_hold=0 and count>0, the head SHALL be popped into dr/wrData with write=1 for the following cycle.
REQ-019 At an edge where wb_hold=1 or count=0, write SHALL become 0; dr and wrData SHALL hold their previous values.
REQ-020 Push and pop at the same edge SHALL both take effect, leaving count unchanged; when count=0 a same-edge push SHALL NOT be popped at that edge.
REQ-021 The minimum latency from a push into an empty queue to write=1 SHALL be 2 edges: push at edge N, pop at edge N+1, and write high in the cycle after N+1.
REQ-022 Entries SHALL drain in strict FIFO order; duplicate in_dr values SHALL each be written, and writes to index 0 SHALL pass through unmodified.
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH, with count tracking fullness without ambiguity.
REQ-024 chk_hit/chk_data SHALL be combinational over the valid queue entries plus the output register when write=1, with priority youngest queue entry > older queue entries > output register.
REQ-025 When there is no match, chk_hit SHALL be 0 and chk_data SHALL be 32'h0.
REQ-026 The lookup SHALL NOT include a same-cycle in_valid request.

Reset
REQ-027 While reset=0 at an edge, the block SHALL set count=0, the pointers to 0, write=0, dr=0 and wrData=0, and SHALL discard the queue contents.
REQ-028 Reset SHALL override a simultaneous push and pop, so that in_valid=1 during the reset edge is not accepted.
REQ-029 In the cycle after reset, in_ready SHALL be 1, chk_hit SHALL be 0, and no write SHALL be issued until a new push is accepted.

Verification
REQ-030 Single write: push {dr=3, data=30} into an empty queue -> write=1, dr=3, wrData=30 for exactly one cycle, 2 edges after the push; count returns to 0.
REQ-031 Fill/full: with wb_hold=1, push 5 requests (dr=k, data=10*k, k=0..4) -> the first 4 are accepted, in_ready=0 and count=4; the 5th is not accepted while in_ready=0; release the hold -> writes for k=0..3 occur in order on consecutive cycles.
REQ-032 Forwarding: queue {5,50} then {5,55} under wb_hold=1, set chk_sr=5 -> chk_hit=1 and chk_data=55; with chk_sr=6 -> chk_hit=0 and chk_data=0.
REQ-033 Simultaneous push and pop at count=2 -> count stays 2 and FIFO order is preserved across a pointer wrap over 3*DEPTH pushes.
REQ-034 Reset mid-operation: with count=3 and write=1, drive reset=0 for one edge -> count=0, write=0, dr=0, wrData=0, and no stale write afterwards.
REQ-035 End-to-end: drive all 32 registers (data=10*k) through the block into the register file, then read them back -> every reg[k] equals 10*k.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register file: buffers pending writes, drains
// them in FIFO order, and forwards the youngest pending data for a source index.

package regfile_wb_queue_pkg;
  typedef struct packed {
    logic [4:0]  dr;
    logic [31:0] data;
  } wb_entry_t;
endpackage

module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_dr,
  input  logic [31:0]              in_data,
  input  logic                     wb_hold,
  output logic [4:0]               dr,
  output logic [31:0]              wrData,
  output logic                     write,
  input  logic [4:0]               chk_sr,
  output logic                     chk_hit,
  output logic [31:0]              chk_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            push;
  logic            pop;
  logic [PW-1:0]   scan_idx;

  // Readiness depends only on occupancy so a same-edge pop never frees a slot early.
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = ~wb_hold & (count != '0);

  // Storage is not reset; count alone decides which slots hold live entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{dr: in_dr, data: in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      write  <= 1'b0;
      dr     <= '0;
      wrData <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        dr     <= mem[head].dr;
        wrData <= mem[head].data;
        write  <= 1'b1;
        head   <= head + PW'(1);
      end else begin
        write  <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Scan oldest to youngest so later matches override earlier ones.
  always_comb begin
    chk_hit  = 1'b0;
    chk_data = '0;
    scan_idx = '0;
    if (write && (dr == chk_sr)) begin
      chk_hit  = 1'b1;
      chk_data = wrData;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head + PW'(i);
      if ((CW'(i) < count) && (mem[scan_idx].dr == chk_sr)) begin
        chk_hit  = 1'b1;
        chk_data = mem[scan_idx].data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: vector table, directed corner cases,
// and random traffic against a queue-based reference model.

module tb_regfile_wb_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_dr = '0;
  logic [31:0]   in_data = '0;
  logic          wb_hold = 1'b0;
  logic [4:0]    dr;
  logic [31:0]   wrData;
  logic          write;
  logic [4:0]    chk_sr = '0;
  logic          chk_hit;
  logic [31:0]   chk_data;
  logic [CW-1:0] count;

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_dr(in_dr), .in_data(in_data), .wb_hold(wb_hold), .dr(dr),
    .wrData(wrData), .write(write), .chk_sr(chk_sr), .chk_hit(chk_hit),
    .chk_data(chk_data), .count(count)
  );

  always #5 clk = ~clk;

  // Register file fed by the block's write port.
  logic [31:0] rf [32];
  always @(posedge clk) if (write) rf[dr] <= wrData;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: a plain queue of pending writes plus the last write-port state.
  typedef struct { logic [4:0] d; logic [31:0] v; } ent_t;
  ent_t        mq[$];
  bit          m_write = 1'b0;
  logic [4:0]  m_dr = '0;
  logic [31:0] m_data = '0;
  bit          last_acc = 1'b0;

  function automatic void model_edge();
    ent_t e;
    bit   room;
    room     = mq.size() < int'(DEPTH);
    last_acc = reset && in_valid && room;
    if (!reset) begin
      mq.delete();
      m_write = 1'b0;
      m_dr    = '0;
      m_data  = '0;
    end else begin
      if (!wb_hold && mq.size() > 0) begin
        e       = mq.pop_front();
        m_write = 1'b1;
        m_dr    = e.d;
        m_data  = e.v;
      end else begin
        m_write = 1'b0;
      end
      if (in_valid && room) begin
        e.d = in_dr;
        e.v = in_data;
        mq.push_back(e);
      end
    end
  endfunction

  function automatic void ref_lookup(input logic [4:0] s, output bit hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!hit && mq[i].d == s) begin
        hit = 1'b1;
        d   = mq[i].v;
      end
    end
    if (!hit && m_write && m_dr == s) begin
      hit = 1'b1;
      d   = m_data;
    end
  endfunction

  task automatic tick();
    bit          e_hit;
    logic [31:0] e_chk;
    @(posedge clk);
    model_edge();
    #1;
    ref_lookup(chk_sr, e_hit, e_chk);
    check("m_ready",  32'(in_ready), 32'(mq.size() < int'(DEPTH)));
    check("m_count",  32'(count),    32'(mq.size()));
    check("m_write",  32'(write),    32'(m_write));
    check("m_dr",     32'(dr),       32'(m_dr));
    check("m_wrData", wrData,        m_data);
    check("m_hit",    32'(chk_hit),  32'(e_hit));
    check("m_chk",    chk_data,      e_chk);
  endtask

  typedef struct {
    bit          rst;
    bit          v;
    logic [4:0]  idr;
    logic [31:0] idata;
    bit          hold;
    logic [4:0]  csr;
    bit          e_ready;
    int          e_count;
    bit          e_write;
    logic [4:0]  e_dr;
    logic [31:0] e_data;
    bit          e_hit;
    logic [31:0] e_chk;
  } vec_t;

  vec_t vecs [11];

  initial begin
    //            rst v  idr idata hold csr rdy cnt wr dr data  hit chk
    vecs[0]  = '{0, 1, 9,  99,  0, 9,  1, 0, 0, 0, 0,  0, 0};
    vecs[1]  = '{1, 1, 3,  30,  0, 3,  1, 1, 0, 0, 0,  1, 30};
    vecs[2]  = '{1, 0, 0,  0,   0, 3,  1, 0, 1, 3, 30, 1, 30};
    vecs[3]  = '{1, 0, 0,  0,   0, 3,  1, 0, 0, 3, 30, 0, 0};
    vecs[4]  = '{1, 1, 5,  50,  1, 5,  1, 1, 0, 3, 30, 1, 50};
    vecs[5]  = '{1, 1, 5,  55,  1, 5,  1, 2, 0, 3, 30, 1, 55};
    vecs[6]  = '{1, 0, 0,  0,   1, 6,  1, 2, 0, 3, 30, 0, 0};
    vecs[7]  = '{1, 1, 0,  7,   0, 5,  1, 2, 1, 5, 50, 1, 55};
    vecs[8]  = '{1, 0, 0,  0,   0, 0,  1, 1, 1, 5, 55, 1, 7};
    vecs[9]  = '{1, 0, 0,  0,   0, 5,  1, 0, 1, 0, 7,  0, 0};
    vecs[10] = '{1, 0, 0,  0,   0, 0,  1, 0, 0, 0, 7,  0, 0};

    for (int r = 0; r < 11; r++) begin
      reset    = vecs[r].rst;
      in_valid = vecs[r].v;
      in_dr    = vecs[r].idr;
      in_data  = vecs[r].idata;
      wb_hold  = vecs[r].hold;
      chk_sr   = vecs[r].csr;
      tick();
      check($sformatf("v%0d_ready", r), 32'(in_ready), 32'(vecs[r].e_ready));
      check($sformatf("v%0d_count", r), 32'(count),    32'(vecs[r].e_count));
      check($sformatf("v%0d_write", r), 32'(write),    32'(vecs[r].e_write));
      check($sformatf("v%0d_dr", r),    32'(dr),       32'(vecs[r].e_dr));
      check($sformatf("v%0d_data", r),  wrData,        vecs[r].e_data);
      check($sformatf("v%0d_hit", r),   32'(chk_hit),  32'(vecs[r].e_hit));
      check($sformatf("v%0d_chk", r),   chk_data,      vecs[r].e_chk);
    end

    // Fill under hold, reject the fifth, then drain in order.
    wb_hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_dr    = 5'(k);
      in_data  = 32'(10 * k);
      tick();
      if (k >= 3) begin
        check("full_ready", 32'(in_ready), 32'(0));
        check("full_count", 32'(count),    32'(4));
      end
    end
    in_valid = 1'b0;
    wb_hold  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("drain_write", 32'(write), 32'(1));
      check("drain_dr",    32'(dr),    32'(k));
      check("drain_data",  wrData,     32'(10 * k));
    end
    tick();
    check("drain_idle", 32'(write), 32'(0));
    check("drain_cnt",  32'(count), 32'(0));

    // Steady push+pop at count=2 across several pointer wraps.
    wb_hold  = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_dr   = 5'(10 + k);
      in_data = 32'(100 + k);
      tick();
    end
    wb_hold = 1'b0;
    for (int i = 0; i < 3 * int'(DEPTH); i++) begin
      in_dr   = 5'(i);
      in_data = 32'(200 + i);
      tick();
      check("wrap_count", 32'(count), 32'(2));
      check("wrap_data",  wrData, (i < 2) ? 32'(100 + i) : 32'(200 + i - 2));
    end
    in_valid = 1'b0;
    repeat (3) tick();

    // Reset while the queue is busy and a write is in flight.
    wb_hold  = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_dr   = 5'(20 + k);
      in_data = 32'(300 + k);
      tick();
    end
    in_valid = 1'b0;
    wb_hold  = 1'b0;
    tick();
    check("mid_count", 32'(count), 32'(3));
    check("mid_write", 32'(write), 32'(1));
    reset    = 1'b0;
    in_valid = 1'b1;
    chk_sr   = 5'd21;
    tick();
    check("rst_count", 32'(count),   32'(0));
    check("rst_write", 32'(write),   32'(0));
    check("rst_dr",    32'(dr),      32'(0));
    check("rst_data",  wrData,       32'(0));
    check("rst_ready", 32'(in_ready), 32'(1));
    check("rst_hit",   32'(chk_hit), 32'(0));
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (4) begin
      tick();
      check("rst_nostale", 32'(write), 32'(0));
    end

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      reset    = ($urandom_range(0, 49) != 0);
      in_valid = 1'($urandom_range(0, 1));
      wb_hold  = ($urandom_range(0, 2) == 0);
      in_dr    = 5'($urandom_range(0, 7));
      in_data  = $urandom;
      chk_sr   = 5'($urandom_range(0, 7));
      tick();
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    wb_hold  = 1'b0;
    repeat (DEPTH + 2) tick();

    // All 32 registers through the block into the register file.
    for (int k = 0; k < 32; k++) begin
      int budget;
      budget   = 0;
      in_valid = 1'b1;
      in_dr    = 5'(k);
      in_data  = 32'(10 * k);
      do begin
        wb_hold = (budget < 5) && ($urandom_range(0, 3) == 0);
        chk_sr  = 5'(k);
        tick();
        budget++;
      end while (!last_acc && budget < 20);
      check("e2e_accept", 32'(last_acc), 32'(1));
    end
    in_valid = 1'b0;
    wb_hold  = 1'b0;
    repeat (DEPTH + 3) tick();
    for (int k = 0; k < 32; k++) begin
      check($sformatf("rf_%0d", k), rf[k], 32'(10 * k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
